// File: rtl/voice_mixer_if.sv
// Voice mixer bus: per-voice samples and note-on flags in, mixed sample out on valid/ready.
// The master side is the synth core plus output serializer; the slave side is the mixer.
interface voice_mixer_if #(
   parameter int AUDIO_WIDTH = 32,
   parameter int NUM_VOICES  = 8,
   parameter int OUT_WIDTH   = 24,
   parameter int GAIN_BITS   = 8
);
   logic [NUM_VOICES*AUDIO_WIDTH-1:0] voice_in;
   logic [NUM_VOICES-1:0]             ons_in;
   logic                              sample_valid;
   logic [OUT_WIDTH-1:0]              out_sample;
   logic                              out_valid;
   logic                              out_ready;
   logic                              overrun;
   logic [NUM_VOICES*GAIN_BITS-1:0]   gains_out;

   modport master (
      output voice_in, ons_in, sample_valid, out_ready,
      input  out_sample, out_valid, overrun, gains_out
   );

   modport slave (
      input  voice_in, ons_in, sample_valid, out_ready,
      output out_sample, out_valid, overrun, gains_out
   );
endinterface

// File: rtl/voice_mixer.sv
// Ramped-gain voice mixer: snapshots all voices, MACs one voice per cycle, saturates to OUT_WIDTH.
// out_valid rises NUM_VOICES+2 cycles after an accepted sample_valid; holds until out_ready, busy pulses drop with overrun.
module voice_mixer #(
   parameter int AUDIO_WIDTH = 32,
   parameter int NUM_VOICES  = 8,
   parameter int OUT_WIDTH   = 24,
   parameter int GAIN_BITS   = 8,
   parameter int RAMP_STEP   = 4,
   parameter int MIX_SHIFT   = 11
) (
   input  logic          clk,
   input  logic          rst,
   voice_mixer_if.slave  bus
);
   localparam int IDX_W  = $clog2(NUM_VOICES);
   localparam int ACC_W  = AUDIO_WIDTH + IDX_W + 1;
   localparam int PROD_W = AUDIO_WIDTH + GAIN_BITS + 1;
   localparam logic [GAIN_BITS:0] STEP = (GAIN_BITS+1)'(RAMP_STEP);
   localparam logic [GAIN_BITS:0] GMAX = {1'b0, {GAIN_BITS{1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (OUT_WIDTH-1)));

   typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;
   state_t state_q, state_d;

   logic [NUM_VOICES*AUDIO_WIDTH-1:0] snap_voice;
   logic [NUM_VOICES-1:0]             snap_on;
   logic signed [ACC_W-1:0]           acc;
   logic [IDX_W-1:0]                  idx;
   logic [GAIN_BITS-1:0]              gain [NUM_VOICES];
   logic [OUT_WIDTH-1:0]              out_sample_q;
   logic                              out_valid_q;
   logic                              overrun_q;

   logic                              last_voice;
   logic                              transfer;
   logic signed [AUDIO_WIDTH-1:0]     cur_voice;
   logic [GAIN_BITS-1:0]              cur_gain;
   logic                              cur_on;
   logic signed [PROD_W-1:0]          product;
   logic signed [ACC_W-1:0]           product_ext;
   logic [GAIN_BITS:0]                gain_up;
   logic [GAIN_BITS-1:0]              gain_next;
   logic signed [ACC_W-1:0]           scaled;
   logic [OUT_WIDTH-1:0]              sat_sample;

   assign last_voice = (idx == IDX_W'(NUM_VOICES-1));
   assign transfer   = out_valid_q && bus.out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.sample_valid) state_d = ACCUM;
         ACCUM:   if (last_voice)       state_d = SCALE;
         SCALE:                         state_d = OUT;
         OUT:     if (transfer)         state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   // Gain is used before it is stepped, so a freshly keyed voice contributes nothing on its first sample.
   always_comb begin
      cur_voice   = snap_voice[idx*AUDIO_WIDTH +: AUDIO_WIDTH];
      cur_gain    = gain[idx];
      cur_on      = snap_on[idx];
      product     = cur_voice * $signed({1'b0, cur_gain});
      product_ext = ACC_W'(product >>> GAIN_BITS);
      gain_up     = {1'b0, cur_gain} + STEP;
      if (cur_on)
         gain_next = (gain_up > GMAX) ? GMAX[GAIN_BITS-1:0] : gain_up[GAIN_BITS-1:0];
      else
         gain_next = ({1'b0, cur_gain} < STEP) ? '0 : cur_gain - STEP[GAIN_BITS-1:0];
      scaled = acc >>> MIX_SHIFT;
      if (scaled > SAT_MAX)
         sat_sample = SAT_MAX[OUT_WIDTH-1:0];
      else if (scaled < SAT_MIN)
         sat_sample = SAT_MIN[OUT_WIDTH-1:0];
      else
         sat_sample = scaled[OUT_WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_voice   <= '0;
         snap_on      <= '0;
         acc          <= '0;
         idx          <= '0;
         out_sample_q <= '0;
         out_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) gain[i] <= '0;
      end else begin
         // Any pulse outside IDLE is dropped, including one coinciding with the output transfer.
         overrun_q <= bus.sample_valid && (state_q != IDLE);
         case (state_q)
            IDLE: begin
               if (bus.sample_valid) begin
                  snap_voice <= bus.voice_in;
                  snap_on    <= bus.ons_in;
                  acc        <= '0;
                  idx        <= '0;
               end
            end
            ACCUM: begin
               acc       <= acc + product_ext;
               gain[idx] <= gain_next;
               idx       <= idx + 1'b1;
            end
            SCALE: begin
               out_sample_q <= sat_sample;
               out_valid_q  <= 1'b1;
            end
            OUT: begin
               if (transfer) out_valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.gains_out = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         bus.gains_out[i*GAIN_BITS +: GAIN_BITS] = gain[i];
   end

   assign bus.out_sample = out_sample_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: three instances (step 4 / step 255 / step 255 with no mix shift)
// share one stimulus stream; each phase checks the instance whose parameters suit it.
module tb_voice_mixer;
   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] voice;
   logic [7:0]   ons;
   logic         sv;
   logic         ordy;
   int           checks = 0;
   int           fails  = 0;

   voice_mixer_if ifa ();
   voice_mixer_if ifb ();
   voice_mixer_if ifc ();

   assign ifa.voice_in = voice;  assign ifa.ons_in = ons;  assign ifa.sample_valid = sv;  assign ifa.out_ready = ordy;
   assign ifb.voice_in = voice;  assign ifb.ons_in = ons;  assign ifb.sample_valid = sv;  assign ifb.out_ready = ordy;
   assign ifc.voice_in = voice;  assign ifc.ons_in = ons;  assign ifc.sample_valid = sv;  assign ifc.out_ready = ordy;

   voice_mixer #(.RAMP_STEP(4))                  dut_a (.clk(clk), .rst(rst), .bus(ifa));
   voice_mixer #(.RAMP_STEP(255))                dut_b (.clk(clk), .rst(rst), .bus(ifb));
   voice_mixer #(.RAMP_STEP(255), .MIX_SHIFT(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_ov(input int sel);
      case (sel)
         0:       return ifa.out_valid;
         1:       return ifb.out_valid;
         default: return ifc.out_valid;
      endcase
   endfunction

   function automatic logic [23:0] get_smp(input int sel);
      case (sel)
         0:       return ifa.out_sample;
         1:       return ifb.out_sample;
         default: return ifc.out_sample;
      endcase
   endfunction

   // Called #1 after a rising edge; returns edges from the accepting edge to out_valid seen.
   task automatic do_sample(input int sel, output int lat, output logic [23:0] smp);
      sv = 1'b1;
      @(posedge clk); #1;
      sv  = 1'b0;
      lat = 1;
      while (!get_ov(sel) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      smp = get_smp(sel);
      if (ordy) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      int          lat;
      logic [23:0] smp;
      logic        seen;
      int          exp3 [7] = '{4, 8, 12, 8, 4, 0, 0};

      rst = 1'b0; sv = 1'b0; ordy = 1'b1; voice = '0; ons = '0;
      repeat (5) @(posedge clk);
      #1;
      chk("reset_out_valid", 64'(ifa.out_valid), 64'd0);
      chk("reset_out_sample", 64'(ifa.out_sample), 64'd0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_out_valid", 64'(ifa.out_valid), 64'd0);
      chk("idle_out_sample", 64'(ifa.out_sample), 64'd0);
      chk("idle_gains", 64'(ifa.gains_out), 64'd0);
      chk("idle_overrun", 64'(ifa.overrun), 64'd0);

      // Single voice with full-scale ramp: first sample silent, second 2^20*255>>8>>11 = 510.
      voice[31:0] = 32'h0010_0000;
      ons = 8'h01;
      do_sample(1, lat, smp);
      chk("imm_lat1", 64'(lat), 64'd10);
      chk("imm_out1", 64'(smp), 64'd0);
      chk("imm_gain0", 64'(ifb.gains_out[7:0]), 64'd255);
      do_sample(1, lat, smp);
      chk("imm_lat2", 64'(lat), 64'd10);
      chk("imm_out2", 64'(smp), 64'd510);

      // Attack then release, step 4, never wrapping below zero.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         ons = (i < 3) ? 8'h01 : 8'h00;
         do_sample(0, lat, smp);
         chk($sformatf("ramp_gain%0d", i), 64'(ifa.gains_out[7:0]), 64'(exp3[i]));
      end

      // Saturation with no mix shift, after preloading every gain to 255.
      do_reset();
      voice = {8{32'h7FFF_FFFF}};
      ons   = 8'hFF;
      do_sample(2, lat, smp);
      chk("sat_preload_gains", 64'(ifc.gains_out), 64'hFFFF_FFFF_FFFF_FFFF);
      do_sample(2, lat, smp);
      chk("sat_pos", 64'(smp), 64'h7F_FFFF);
      voice = {8{32'h8000_0000}};
      do_sample(2, lat, smp);
      chk("sat_neg", 64'(smp), 64'h80_0000);

      // Backpressure: hold the output, drop two pulses, then one transfer with a coinciding pulse.
      do_reset();
      voice = '0;
      voice[31:0] = 32'h0010_0000;
      ons = 8'h01;
      do_sample(0, lat, smp);
      ordy = 1'b0;
      do_sample(0, lat, smp);
      chk("bp_lat", 64'(lat), 64'd10);
      chk("bp_out", 64'(smp), 64'd8);
      for (int p = 0; p < 2; p++) begin
         sv = 1'b1;
         @(posedge clk); #1;
         sv = 1'b0;
         chk($sformatf("bp_overrun_hi%0d", p), 64'(ifa.overrun), 64'd1);
         @(posedge clk); #1;
         chk($sformatf("bp_overrun_lo%0d", p), 64'(ifa.overrun), 64'd0);
      end
      chk("bp_hold_valid", 64'(ifa.out_valid), 64'd1);
      chk("bp_hold_sample", 64'(ifa.out_sample), 64'd8);
      chk("bp_hold_gain", 64'(ifa.gains_out[7:0]), 64'd8);
      ordy = 1'b1;
      sv   = 1'b1;
      @(posedge clk); #1;
      sv = 1'b0;
      chk("bp_xfer_valid", 64'(ifa.out_valid), 64'd0);
      chk("bp_xfer_overrun", 64'(ifa.overrun), 64'd1);
      repeat (11) @(posedge clk);
      #1;
      chk("bp_dropped_no_valid", 64'(ifa.out_valid), 64'd0);
      chk("bp_kept_sample", 64'(ifa.out_sample), 64'd8);
      do_sample(0, lat, smp);
      chk("bp_next_lat", 64'(lat), 64'd10);
      chk("bp_next_out", 64'(smp), 64'd16);
      chk("bp_next_gain", 64'(ifa.gains_out[7:0]), 64'd12);

      // Reset four cycles into an accumulation.
      sv = 1'b1;
      @(posedge clk); #1;
      sv = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      chk("mid_rst_gains", 64'(ifa.gains_out), 64'd0);
      @(posedge clk); #1;
      rst  = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 14; c++) begin
         @(posedge clk); #1;
         if (ifa.out_valid) seen = 1'b1;
      end
      chk("mid_rst_no_valid", 64'(seen), 64'd0);
      chk("mid_rst_sample", 64'(ifa.out_sample), 64'd0);
      do_sample(0, lat, smp);
      chk("post_rst_lat", 64'(lat), 64'd10);
      chk("post_rst_out", 64'(smp), 64'd0);
      chk("post_rst_gain", 64'(ifa.gains_out[7:0]), 64'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
